// File: rtl/div_unit_pkg.sv
// Shared state encodings and handshake levels for the multi-cycle divider.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration, purely combinational.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] part_rem,
   input  logic              next_bit,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
);

   logic              neg;
   logic [DATA_W-1:0] trial;

   // part_rem < divisor always holds, so the DATA_W+1-bit difference lies in
   // [-divisor, divisor) and its top bit is the borrow.
   assign {neg, trial} = {part_rem, next_bit} - {1'b0, divisor};

   assign q_bit    = ~neg;
   assign rem_next = neg ? {part_rem[DATA_W-2:0], next_bit} : trial;

endmodule

// File: rtl/div_unit.sv
// Signed/unsigned restoring divider, one bit per cycle, result {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish in two cycles when |dividend| < |divisor|.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam logic [CNT_W-1:0] CntDone = CNT_W'(DATA_W);

   div_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem, dq, divisor_mag;
   logic              sgn_a, sgn_b;
   logic [DATA_W-1:0] mag_a, mag_b, step_rem, quo_fix, rem_fix;
   logic              step_q, accept, early_out;

   assign mag_a  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign mag_b  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
   assign accept = (start_i == DivStart) && !annul_i;

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (mag_a < mag_b);
`else
   assign early_out = 1'b0;
`endif

   // dq starts as the dividend; its MSB feeds each step and quotient bits shift in.
   div_step #(.DATA_W(DATA_W)) u_step (
      .part_rem (rem),
      .next_bit (dq[DATA_W-1]),
      .divisor  (divisor_mag),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   assign quo_fix = (sgn_a ^ sgn_b) ? -dq : dq;
   assign rem_fix = sgn_a ? -rem : rem;

   always_comb begin
      state_nxt = state;
      case (state)
         DivFree:   if (accept) state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
         DivByZero: state_nxt = DivEnd;
         DivOn: begin
            if (annul_i)             state_nxt = DivFree;
            else if (cnt == CntDone) state_nxt = DivEnd;
         end
         DivEnd:    if (start_i == DivStop) state_nxt = DivFree;
         default:   state_nxt = DivFree;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= DivFree;
         cnt         <= '0;
         rem         <= '0;
         dq          <= '0;
         divisor_mag <= '0;
         sgn_a       <= 1'b0;
         sgn_b       <= 1'b0;
         result_o    <= '0;
         ready_o     <= DivResultNotReady;
      end else begin
         state <= state_nxt;
         case (state)
            DivFree: begin
               if (accept && opdata2_i != '0) begin
                  sgn_a       <= signed_div_i & opdata1_i[DATA_W-1];
                  sgn_b       <= signed_div_i & opdata2_i[DATA_W-1];
                  divisor_mag <= mag_b;
                  // Early-out reuses the sign-fix cycle with the count already done.
                  if (early_out) begin
                     cnt <= CntDone;
                     rem <= mag_a;
                     dq  <= '0;
                  end else begin
                     cnt <= '0;
                     rem <= '0;
                     dq  <= mag_a;
                  end
               end
            end
            DivByZero: begin
               result_o <= '0;
               ready_o  <= DivResultReady;
            end
            DivOn: begin
               if (!annul_i) begin
                  if (cnt != CntDone) begin
                     rem <= step_rem;
                     dq  <= {dq[DATA_W-2:0], step_q};
                     cnt <= cnt + 1'b1;
                  end else begin
                     result_o <= {rem_fix, quo_fix};
                     ready_o  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a behavioural division model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst, start_i, annul_i, signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] sb_q[$];

   div_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
      logic signed [31:0] sa, sb;
      logic [31:0]        q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic int lat_model(input logic [31:0] a, input logic [31:0] b, input logic sg);
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
      begin
         logic [31:0] ma, mb;
         ma = (sg && a[31]) ? -a : a;
         mb = (sg && b[31]) ? -b : b;
         if (ma < mb) return 2;
      end
`endif
      return 34;
   endfunction

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic drop_early);
      int          cyc, lat;
      logic [63:0] exp;
      sb_q.push_back(model(a, b, sg));
      lat          = lat_model(a, b, sg);
      start_i      = 1'b1;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sg;
      cyc          = 0;
      do begin
         tick();
         cyc++;
         if (cyc == 1) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sg;
            if (drop_early) start_i = 1'b0;
         end
      end while (!ready_o && cyc < 100);
      exp = sb_q.pop_front();
      chk("latency", 64'(cyc), 64'(lat));
      chk("result", result_o, exp);
      if (!drop_early) begin
         tick();
         chk("ready_hold", {63'd0, ready_o}, 64'd1);
         chk("result_hold", result_o, exp);
         start_i = 1'b0;
      end
      tick();
      chk("ready_clear", {63'd0, ready_o}, 64'd0);
      chk("result_clear", result_o, 64'd0);
   endtask

   initial begin
      logic        any_ready;
      logic [63:0] exp;
      int          cyc;
      logic [31:0] ra, rb;
      rst          = 1'b0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      tick();
      tick();
      chk("reset_ready", {63'd0, ready_o}, 64'd0);
      chk("reset_result", result_o, 64'd0);
      rst = 1'b1;
      tick();

      run_div(32'd100, 32'd7, 1'b0, 1'b0);
      run_div(-32'd7, 32'd2, 1'b1, 1'b0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_div(32'h1234, 32'd0, 1'b0, 1'b0);
      run_div(32'd3, 32'd10, 1'b0, 1'b0);
      run_div(-32'd100, 32'd7, 1'b1, 1'b1);
      run_div(32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);

      // start and annul together in FREE must be ignored
      start_i   = 1'b1;
      annul_i   = 1'b1;
      opdata1_i = 32'd9;
      opdata2_i = 32'd0;
      tick();
      tick();
      tick();
      chk("both_high_ignored", {63'd0, ready_o}, 64'd0);
      start_i = 1'b0;
      annul_i = 1'b0;
      tick();

      // annul in cycle 10, restart in cycle 12
      start_i   = 1'b1;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      any_ready = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         any_ready |= ready_o;
      end
      annul_i = 1'b1;
      tick();
      any_ready |= ready_o;
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();
      any_ready |= ready_o;
      chk("annul_no_ready", {63'd0, any_ready}, 64'd0);
      run_div(32'd1000, 32'd3, 1'b0, 1'b0);

      // reset at cycle 20 of a divide
      start_i   = 1'b1;
      opdata1_i = 32'd50000;
      opdata2_i = 32'd9;
      for (int c = 1; c <= 20; c++) tick();
      rst     = 1'b0;
      start_i = 1'b0;
      tick();
      chk("midreset_ready", {63'd0, ready_o}, 64'd0);
      chk("midreset_result", result_o, 64'd0);
      rst = 1'b1;
      tick();
      run_div(32'd50000, 32'd9, 1'b0, 1'b0);

      // reset asserted during DIV_END takes effect only at the clock edge
      sb_q.push_back(model(32'd21, 32'd4, 1'b0));
      start_i   = 1'b1;
      opdata1_i = 32'd21;
      opdata2_i = 32'd4;
      cyc       = 0;
      do begin
         tick();
         cyc++;
      end while (!ready_o && cyc < 100);
      exp = sb_q.pop_front();
      chk("sync_pre_result", result_o, exp);
      rst = 1'b0;
      #2;
      chk("sync_hold_ready", {63'd0, ready_o}, 64'd1);
      chk("sync_hold_result", result_o, exp);
      tick();
      chk("sync_reset_ready", {63'd0, ready_o}, 64'd0);
      chk("sync_reset_result", result_o, 64'd0);
      start_i = 1'b0;
      rst     = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         if (i == 5) ra = 32'($urandom_range(0, 50));
         run_div(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
